// File: rtl/edge_trig_pkg.sv
// edge_trig_pkg: state encoding and default sizing for the edge-trigger sequencer
package edge_trig_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, PRIME, ARMED, HOLDOFF} state_t;
  localparam int TRIG_CNT_W = 16;
  localparam int FLUSH_CYCLES_DEF = 4;
  localparam int HOLDOFF_W_DEF = 16;
  localparam int TIMEOUT_W_DEF = 24;
endpackage

// File: rtl/edge_seq_dncnt.sv
// edge_seq_dncnt: loadable down-counter that stops at zero and flags it
module edge_seq_dncnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/edge_trig_seq.sv
// edge_trig_seq: arm/flush/prime/trigger sequencer; EDGE_TRIG_SEQ_TIMEOUT_EN adds a forced-trigger timeout
module edge_trig_seq
  import edge_trig_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int HOLDOFF_W = HOLDOFF_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  continuous_i,
  input  logic [7:0]            window_width_i,
  input  logic [HOLDOFF_W-1:0]  holdoff_i,
  input  logic [TIMEOUT_W-1:0]  timeout_i,
  input  logic                  sum_wr_i,
  input  logic                  trig_in_i,
  output logic                  core_rst_o,
  output logic                  core_start_o,
  output logic                  trig_out_o,
  output logic                  armed_o,
  output logic                  busy_o,
  output logic [TRIG_CNT_W-1:0] trig_count_o,
  output logic                  timed_out_o
);
  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  state_t state, nxt;
  logic flush_zero, prime_zero, hold_zero, forced, fire;
  logic enter_flush, enter_prime, enter_armed, enter_hold;
  assign fire = state == ARMED && !abort_i && (trig_in_i || forced);
  assign enter_flush = state == IDLE && arm_i && !abort_i;
  assign enter_prime = state == FLUSH && flush_zero;
  assign enter_hold = fire && continuous_i && holdoff_i != '0;
  assign enter_armed = (state == PRIME && sum_wr_i && prime_zero) || (state == HOLDOFF && hold_zero) ||
                       (fire && continuous_i && holdoff_i == '0);
  edge_seq_dncnt #(.W(FW)) u_flush (
    .clk(clk), .rst(reset_i), .load(enter_flush), .load_val(FW'(FLUSH_CYCLES - 1)),
    .en(state == FLUSH), .zero(flush_zero)
  );
  edge_seq_dncnt #(.W(8)) u_prime (
    .clk(clk), .rst(reset_i), .load(enter_prime),
    .load_val(window_width_i == 8'd0 ? 8'd0 : window_width_i - 8'd1),
    .en(state == PRIME && sum_wr_i), .zero(prime_zero)
  );
  edge_seq_dncnt #(.W(HOLDOFF_W)) u_hold (
    .clk(clk), .rst(reset_i), .load(enter_hold), .load_val(holdoff_i - 1'b1),
    .en(state == HOLDOFF), .zero(hold_zero)
  );
`ifdef EDGE_TRIG_SEQ_TIMEOUT_EN
  logic to_zero;
  edge_seq_dncnt #(.W(TIMEOUT_W)) u_timeout (
    .clk(clk), .rst(reset_i), .load(enter_armed), .load_val(timeout_i - 1'b1),
    .en(state == ARMED), .zero(to_zero)
  );
  // a real edge in the same cycle takes precedence, so forced stays low then
  assign forced = state == ARMED && !trig_in_i && timeout_i != '0 && to_zero;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign forced = 1'b0;
`endif
  always_comb
    nxt = abort_i ? IDLE :
          enter_flush ? FLUSH :
          enter_prime ? PRIME :
          enter_armed ? ARMED :
          enter_hold ? HOLDOFF :
          fire ? IDLE : state;
  always_ff @(posedge clk)
    if (reset_i) begin
      state <= IDLE;
      core_rst_o <= 1'b1;
      core_start_o <= 1'b0;
      trig_out_o <= 1'b0;
      armed_o <= 1'b0;
      busy_o <= 1'b0;
      trig_count_o <= '0;
      timed_out_o <= 1'b0;
    end else begin
      state <= nxt;
      core_rst_o <= nxt == IDLE || nxt == FLUSH;
      core_start_o <= !(nxt == IDLE || nxt == FLUSH);
      trig_out_o <= fire;
      armed_o <= nxt == ARMED;
      busy_o <= nxt != IDLE;
      if (enter_flush) trig_count_o <= '0;
      else if (fire && trig_count_o != '1) trig_count_o <= trig_count_o + 1'b1;
      if (enter_flush) timed_out_o <= 1'b0;
      else if (fire) timed_out_o <= forced;
    end
endmodule

// File: tb/tb_edge_trig_seq.sv
// tb_edge_trig_seq: randomized scenario bench for edge_trig_seq with a cycle-arithmetic reference model
module tb_edge_trig_seq;
  localparam int FLUSH = 4;
  logic clk = 1'b0;
  logic reset_i, arm_i, abort_i, continuous_i, sum_wr_i, trig_in_i;
  logic [7:0] window_width_i;
  logic [15:0] holdoff_i;
  logic [23:0] timeout_i;
  logic core_rst_o, core_start_o, trig_out_o, armed_o, busy_o, timed_out_o;
  logic [15:0] trig_count_o;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  edge_trig_seq #(.FLUSH_CYCLES(FLUSH), .HOLDOFF_W(16), .TIMEOUT_W(24)) dut (
    .clk(clk), .reset_i(reset_i), .arm_i(arm_i), .abort_i(abort_i), .continuous_i(continuous_i),
    .window_width_i(window_width_i), .holdoff_i(holdoff_i), .timeout_i(timeout_i),
    .sum_wr_i(sum_wr_i), .trig_in_i(trig_in_i), .core_rst_o(core_rst_o), .core_start_o(core_start_o),
    .trig_out_o(trig_out_o), .armed_o(armed_o), .busy_o(busy_o), .trig_count_o(trig_count_o),
    .timed_out_o(timed_out_o)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tests++;
    if (busy_o !== 1'b0 || core_rst_o !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle: busy=%b core_rst=%b want 0/1", busy_o, core_rst_o);
    end
  endtask
  // arm, check the flush length, then feed random sum_wr pulses until ARMED
  task automatic do_prime(input int w);
    int need;
    int seen;
    int n;
    need = (w == 0) ? 1 : w;
    seen = 0;
    n = 0;
    window_width_i = 8'(w);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int i = 0; i < FLUSH; i++) begin
      tests++;
      if (core_rst_o !== 1'b1 || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL flush_rst[%0d]: core_rst=%b busy=%b want 1/1", i, core_rst_o, busy_o);
      end
      tick();
    end
    tests++;
    if (core_rst_o !== 1'b0 || core_start_o !== 1'b1) begin
      fails++;
      $display("FAIL prime_entry: core_rst=%b start=%b want 0/1", core_rst_o, core_start_o);
    end
    window_width_i = 8'($urandom_range(0, 255));
    while (seen < need && n < 200) begin
      sum_wr_i = 1'($urandom_range(0, 1));
      trig_in_i = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (sum_wr_i) seen++;
      tests++;
      if (trig_out_o !== 1'b0 || armed_o !== (seen >= need)) begin
        fails++;
        $display("FAIL prime_step w=%0d seen=%0d: trig=%b armed=%b want 0/%b", w, seen, trig_out_o, armed_o, seen >= need);
      end
    end
    sum_wr_i = 1'b0;
    trig_in_i = 1'b0;
  endtask
  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    tests++;
    if ({core_rst_o, core_start_o, trig_out_o, armed_o, busy_o, timed_out_o, trig_count_o} !== {6'b100000, 16'h0}) begin
      fails++;
      $display("FAIL reset_vals: got %b %b %b %b %b %b %h", core_rst_o, core_start_o, trig_out_o, armed_o, busy_o, timed_out_o, trig_count_o);
    end
    reset_i = 1'b0;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    repeat (FLUSH + 1) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tests++;
    if (core_rst_o !== 1'b1 || core_start_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: core_rst=%b start=%b busy=%b want 1/0/0", core_rst_o, core_start_o, busy_o);
    end
  endtask
  task automatic test_single_shot();
    continuous_i = 1'b0;
    do_prime(3);
    repeat ($urandom_range(0, 5)) begin
      tick();
      tests++;
      if (trig_out_o !== 1'b0 || armed_o !== 1'b1) begin
        fails++;
        $display("FAIL ss_wait: trig=%b armed=%b want 0/1", trig_out_o, armed_o);
      end
    end
    trig_in_i = 1'b1;
    tick();
    trig_in_i = 1'b0;
    tests++;
    if (trig_out_o !== 1'b1 || trig_count_o !== 16'd1 || busy_o !== 1'b0 || core_rst_o !== 1'b1) begin
      fails++;
      $display("FAIL ss_trig: trig=%b cnt=%0d busy=%b core_rst=%b want 1/1/0/1", trig_out_o, trig_count_o, busy_o, core_rst_o);
    end
    tick();
    tests++;
    if (trig_out_o !== 1'b0) begin
      fails++;
      $display("FAIL ss_pulse_width: trig=%b want 0", trig_out_o);
    end
  endtask
  task automatic test_flush_prime();
    continuous_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_prime((k == 0) ? 0 : $urandom_range(1, 6));
      do_abort();
    end
  endtask
  // model: an edge at cycle c is accepted iff c >= next_ok; acceptance moves next_ok to c+H+1
  task automatic test_continuous(input int h, input bit directed);
    int next_ok;
    int cnt;
    bit exp_t;
    next_ok = 0;
    cnt = 0;
    continuous_i = 1'b1;
    holdoff_i = 16'(h);
    do_prime($urandom_range(1, 4));
    for (int c = 0; c < 60; c++) begin
      trig_in_i = directed ? (c == 0 || c == 5 || c == 12) : ($urandom_range(0, 2) == 0);
      tick();
      exp_t = trig_in_i && c >= next_ok;
      if (exp_t) begin
        cnt++;
        next_ok = c + h + 1;
      end
      tests++;
      if (trig_out_o !== exp_t || trig_count_o !== 16'(cnt) || armed_o !== (c + 1 >= next_ok)) begin
        fails++;
        $display("FAIL cont h=%0d c=%0d: trig=%b cnt=%0d armed=%b want %b/%0d/%b", h, c, trig_out_o, trig_count_o, armed_o, exp_t, cnt, c + 1 >= next_ok);
      end
    end
    trig_in_i = 1'b0;
    do_abort();
  endtask
  task automatic test_abort();
    continuous_i = 1'b0;
    do_prime(2);
    abort_i = 1'b1;
    trig_in_i = 1'b1;
    tick();
    abort_i = 1'b0;
    trig_in_i = 1'b0;
    tests++;
    if (trig_out_o !== 1'b0 || busy_o !== 1'b0 || core_rst_o !== 1'b1 || trig_count_o !== 16'd0) begin
      fails++;
      $display("FAIL abort_vs_trig: trig=%b busy=%b core_rst=%b cnt=%0d want 0/0/1/0", trig_out_o, busy_o, core_rst_o, trig_count_o);
    end
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i = 1'b0;
    abort_i = 1'b0;
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL abort_vs_arm: busy=%b want 0", busy_o);
    end
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    tick();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    tick();
    tick();
    tests++;
    if (core_rst_o !== 1'b0 || core_start_o !== 1'b1) begin
      fails++;
      $display("FAIL rearm_ignored: core_rst=%b start=%b want 0/1", core_rst_o, core_start_o);
    end
    do_abort();
  endtask
  task automatic test_saturation();
    continuous_i = 1'b1;
    holdoff_i = 16'd0;
    do_prime(1);
    trig_in_i = 1'b1;
    repeat (65534) tick();
    tests++;
    if (trig_count_o !== 16'hFFFE || trig_out_o !== 1'b1) begin
      fails++;
      $display("FAIL sat_pre: cnt=%h trig=%b want fffe/1", trig_count_o, trig_out_o);
    end
    repeat (6) tick();
    trig_in_i = 1'b0;
    tests++;
    if (trig_count_o !== 16'hFFFF || trig_out_o !== 1'b1) begin
      fails++;
      $display("FAIL sat_hold: cnt=%h trig=%b want ffff/1", trig_count_o, trig_out_o);
    end
    tick();
    tests++;
    if (trig_count_o !== 16'hFFFF || trig_out_o !== 1'b0 || armed_o !== 1'b1) begin
      fails++;
      $display("FAIL sat_end: cnt=%h trig=%b armed=%b want ffff/0/1", trig_count_o, trig_out_o, armed_o);
    end
    do_abort();
  endtask
  task automatic test_timeout();
    int n;
    int t;
    bit seen;
    continuous_i = 1'b0;
    holdoff_i = 16'd0;
`ifdef EDGE_TRIG_SEQ_TIMEOUT_EN
    timeout_i = 24'd100;
    do_prime(2);
    n = 0;
    while (trig_out_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (n != 100 || timed_out_o !== 1'b1 || trig_count_o !== 16'd1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_force: after %0d cycles timed_out=%b cnt=%0d busy=%b want 100/1/1/0", n, timed_out_o, trig_count_o, busy_o);
    end
    t = $urandom_range(3, 20);
    timeout_i = 24'(t);
    do_prime(1);
    repeat (t - 1) tick();
    trig_in_i = 1'b1;
    tick();
    trig_in_i = 1'b0;
    tests++;
    if (trig_out_o !== 1'b1 || timed_out_o !== 1'b0 || trig_count_o !== 16'd1) begin
      fails++;
      $display("FAIL timeout_real_wins t=%0d: trig=%b timed_out=%b cnt=%0d want 1/0/1", t, trig_out_o, timed_out_o, trig_count_o);
    end
`else
    timeout_i = 24'd100;
    do_prime(2);
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (trig_out_o === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0 || timed_out_o !== 1'b0 || armed_o !== 1'b1) begin
      fails++;
      $display("FAIL timeout_off: pulse=%b timed_out=%b armed=%b want 0/0/1", seen, timed_out_o, armed_o);
    end
    do_abort();
`endif
    timeout_i = 24'd0;
  endtask
  initial begin
    reset_i = 1'b1;
    arm_i = 1'b0;
    abort_i = 1'b0;
    continuous_i = 1'b0;
    sum_wr_i = 1'b0;
    trig_in_i = 1'b0;
    window_width_i = 8'd0;
    holdoff_i = 16'd0;
    timeout_i = 24'd0;
    test_reset();
    test_single_shot();
    test_flush_prime();
    test_continuous(10, 1'b1);
    test_continuous(0, 1'b0);
    test_continuous($urandom_range(1, 6), 1'b0);
    test_abort();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
